// File: rtl/manchester_pkg.sv
// ============================================================================
// Module  : manchester_pkg
// Brief   : Shared types and helpers for the Manchester receive path:
//           FSM state encoding, line polarity and timing window bounds.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package manchester_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    GAP  = 2'd2
  } manch_state_e;

  // IEEE 802.3 polarity: a rising mid-bit transition carries a 1
  localparam logic MANCH_RISE_IS_ONE = 1'b1;

  // Earliest accepted mid-bit spacing, in clock cycles
  function automatic int manch_win_lo(input int osr);
    return osr - osr / 4;
  endfunction

  // Latest accepted mid-bit spacing, in clock cycles
  function automatic int manch_win_hi(input int osr);
    return osr + osr / 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/manchester_decoder_if.sv
// ============================================================================
// Module  : manchester_decoder_if
// Brief   : Byte output bundle of the Manchester decoder: valid/ready byte
//           handoff plus error/overrun pulses and the error counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface manchester_decoder_if;

  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       err;
  logic       overrun;
  logic [7:0] err_cnt;

  // Decoder side
  modport master (
    output data_out,
    output data_valid,
    input  data_ready,
    output err,
    output overrun,
    output err_cnt
  );

  // Consumer side
  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready,
    input  err,
    input  overrun,
    input  err_cnt
  );

endinterface

`default_nettype wire

// File: rtl/manchester_edge_sync.sv
// ============================================================================
// Module  : manchester_edge_sync
// Brief   : Two-flop synchronizer for the asynchronous serial line followed
//           by a previous-sample flop; reports level, any edge, rising edge.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module manchester_edge_sync (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic line_in,
  output logic      lvl,
  output logic      edge_det,
  output logic      rise
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Next values of the synchronizer chain and the history flop
  always_comb begin
    s1_d = line_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Shift the line through the chain; reset clears every stage to idle-low
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign lvl      = s2_q;
  assign edge_det = s2_q ^ s3_q;
  assign rise     = s2_q & ~s3_q;

endmodule

`default_nettype wire

// File: rtl/manchester_decoder.sv
// ============================================================================
// Module  : manchester_decoder
// Brief   : Oversampling Manchester receiver. Locks onto the start-bit mid
//           transition, recovers 8 bits LSB first and hands each byte out
//           through a single-entry valid/ready register.
//           Optional: MANCH_ERR_CNT_EN adds a saturating err/overrun counter;
//           without it err_cnt reads 8'h00.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module manchester_decoder
  import manchester_pkg::*;
#(
  parameter int OSR = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             line_in,
  manchester_decoder_if.master  bus
);

  localparam int CNT_W = $clog2(2 * OSR) + 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_DATA = DATA;
  localparam logic [1:0] ST_GAP  = GAP;

  localparam logic [CNT_W:0]   LO_C    = (CNT_W + 1)'(manch_win_lo(OSR));
  localparam logic [CNT_W:0]   HI_C    = (CNT_W + 1)'(manch_win_hi(OSR));
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(OSR - 1);

  logic w_lvl, w_edge, w_rise;

  manchester_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .line_in  (line_in),
    .lvl      (w_lvl),
    .edge_det (w_edge),
    .rise     (w_rise)
  );

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q,   shreg_d;
  logic [7:0]       data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             err_q,     err_d;
  logic             overrun_q, overrun_d;

  // cnt restarts at 0 in the cycle a mid-bit edge is taken, so the spacing
  // between two mid-bit edges seen in the current cycle is cnt + 1.
  logic [CNT_W:0] w_elapsed;
  logic           w_bit;
  logic           w_accept;
  logic           w_mid;

  assign w_elapsed = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign w_bit     = (w_lvl == MANCH_RISE_IS_ONE);
  assign w_accept  = valid_q & bus.data_ready;
  assign w_mid     = w_edge && (w_elapsed >= LO_C) && (w_elapsed <= HI_C);

  // Frame FSM, bit timing, shift register and byte handoff
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q & ~w_accept;
    err_d     = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a rising edge can be a start-bit mid transition
        if (w_rise) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          shreg_d   = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_mid) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = w_bit;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_GAP;
            if (!valid_q || w_accept) begin
              data_d  = {w_bit, shreg_q[6:0]};
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end else if (w_elapsed > HI_C) begin
          // Mid-bit transition never came: drop the partial byte
          err_d   = 1'b1;
          cnt_d   = '0;
          shreg_d = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        // cnt counts consecutive low samples; any high sample restarts it
        if (w_lvl) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register FSM, datapath and output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.err        = err_q;
  assign bus.overrun    = overrun_q;

`ifdef MANCH_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of err and overrun events, in step with the pulses
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((err_d || overrun_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 8'h00;
`endif

endmodule

`default_nettype wire
